hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. It decides every cycle whether to hold the PC and the IF/ID register, squash IF/ID, bubble or hold ID/EX (via `stop_ID` and the ID/EX hold enable), and freeze EX/MEM. It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle DRAM waits. It also remembers a branch flush that arrives while the pipeline is frozen.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned WIDTH_REGMARK  = 5;
  localparam int unsigned WIDTH_HZ_STATE = 2;
  localparam int unsigned WIDTH_HZ_CNT   = 3;

  typedef enum logic [WIDTH_HZ_STATE-1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_FLUSH    = 2'd2
  } hz_state_e;

  function automatic logic src_hit(input logic used,
                                   input logic [WIDTH_REGMARK-1:0] rs,
                                   input logic [WIDTH_REGMARK-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the optional hazard performance counters.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch / DRAM-wait hazard controller for the five-stage core.
// Define HAZARD_PERF_CNT_EN to add the three saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned BRANCH_PENALTY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH_REGMARK-1:0] id_rs1,
  input  logic [WIDTH_REGMARK-1:0] id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [WIDTH_REGMARK-1:0] ex_regwr,
  input  logic                     ex_regwe,
  input  logic                     ex_is_load,
  input  logic                     ex_branch_taken,
  input  logic                     mem_busy,
  output logic                     stall_pc,
  output logic                     stall_if_id,
  output logic                     flush_if_id,
  output logic                     stop_id,
  output logic                     hold_id_ex,
  output logic                     hold_ex_mem,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]              perf_load_use,
  output logic [31:0]              perf_flush,
  output logic [31:0]              perf_mem_wait,
`endif
  output logic                     busy
);

  localparam logic [WIDTH_HZ_CNT-1:0] PEN_RELOAD = WIDTH_HZ_CNT'(BRANCH_PENALTY - 1);

  hz_state_e                state;
  logic [WIDTH_HZ_CNT-1:0]  cnt;
  logic                     pend;
  logic                     load_use;
  logic                     branch_now;
  logic                     resume_flush;

  assign load_use = ex_is_load && ex_regwe && (ex_regwr != '0) &&
                    (src_hit(id_rs1_used, id_rs1, ex_regwr) ||
                     src_hit(id_rs2_used, id_rs2, ex_regwr));
  assign branch_now = ex_branch_taken || pend;
  // A non-zero cnt parked in MEM_WAIT is a FLUSH interrupted by the freeze;
  // its next bubble is issued in the first unfrozen cycle, before leaving MEM_WAIT.
  assign resume_flush = (state == HZ_FLUSH) || ((state == HZ_MEM_WAIT) && (cnt != '0));

  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    stop_id     = 1'b0;
    hold_id_ex  = 1'b0;
    hold_ex_mem = 1'b0;
    if (!rst_n) begin
      stall_pc = 1'b0;
    end else if (mem_busy) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      hold_id_ex  = 1'b1;
      hold_ex_mem = 1'b1;
    end else if (branch_now || resume_flush) begin
      flush_if_id = 1'b1;
      stop_id     = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      stop_id     = 1'b1;
    end
  end

  assign busy = rst_n && (state != HZ_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HZ_RUN;
      cnt   <= '0;
      pend  <= 1'b0;
    end else if (mem_busy) begin
      state <= HZ_MEM_WAIT;
      if (ex_branch_taken)
        pend <= 1'b1;
    end else if (branch_now) begin
      pend <= 1'b0;
      if (BRANCH_PENALTY > 1) begin
        state <= HZ_FLUSH;
        cnt   <= PEN_RELOAD;
      end else begin
        state <= HZ_RUN;
        cnt   <= '0;
      end
    end else if (resume_flush && (cnt > WIDTH_HZ_CNT'(1))) begin
      state <= HZ_FLUSH;
      cnt   <= cnt - WIDTH_HZ_CNT'(1);
    end else begin
      state <= HZ_RUN;
      cnt   <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_perf_load_use (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_pc && stop_id),
    .count (perf_load_use)
  );

  sat_counter #(.WIDTH(32)) u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_if_id),
    .count (perf_flush)
  );

  sat_counter #(.WIDTH(32)) u_perf_mem_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hold_ex_mem),
    .count (perf_mem_wait)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (BRANCH_PENALTY=3); perf checks only with HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_regwr;
  logic       id_rs1_used, id_rs2_used, ex_regwe, ex_is_load, ex_branch_taken, mem_busy;
  logic       stall_pc, stall_if_id, flush_if_id, stop_id, hold_id_ex, hold_ex_mem, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use, perf_flush, perf_mem_wait;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.BRANCH_PENALTY(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_regwr        (ex_regwr),
    .ex_regwe        (ex_regwe),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .stop_id         (stop_id),
    .hold_id_ex      (hold_id_ex),
    .hold_ex_mem     (hold_ex_mem),
`ifdef HAZARD_PERF_CNT_EN
    .perf_load_use   (perf_load_use),
    .perf_flush      (perf_flush),
    .perf_mem_wait   (perf_mem_wait),
`endif
    .busy            (busy)
  );

  // Output bundle order: stall_pc stall_if_id flush_if_id stop_id hold_id_ex hold_ex_mem busy
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1101000;
  localparam logic [6:0] O_BR    = 7'b0011000;
  localparam logic [6:0] O_FL    = 7'b0011001;
  localparam logic [6:0] O_FRZ0  = 7'b1100110;
  localparam logic [6:0] O_FRZ   = 7'b1100111;
  localparam logic [6:0] O_WEXIT = 7'b0000001;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, ld;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] outs();
    return {stall_pc, stall_if_id, flush_if_id, stop_id, hold_id_ex, hold_ex_mem, busy};
  endfunction

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_regwr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_regwe = 1'b0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_regwr = rd; ex_regwe = we; ex_is_load = ld;
  endtask

  // Inputs are applied on the falling edge; outputs are compared 1 time unit later.
  task automatic chk(input string name, input logic [6:0] exp);
    #1;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, outs(), exp);
    end
    @(negedge clk);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
`endif

  initial begin
    vecs[0] = '{"lu_rs2",      5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, O_LU};
    vecs[1] = '{"lu_rd_x0",    5'd3,  5'd5, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, O_IDLE};
    vecs[2] = '{"lu_all_x0",   5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, O_IDLE};
    vecs[3] = '{"lu_rs1",      5'd7,  5'd2, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, O_LU};
    vecs[4] = '{"lu_rs1_unused",5'd7, 5'd2, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, O_IDLE};
    vecs[5] = '{"lu_no_we",    5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1, O_IDLE};
    vecs[6] = '{"lu_not_load", 5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, O_IDLE};
    vecs[7] = '{"lu_r31",      5'd31, 5'd1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};

    rst_n = 1'b0;
    clear_in();
    mem_busy = 1'b1;
    ex_branch_taken = 1'b1;
    chk("reset_outputs", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();
    chk("after_reset", O_IDLE);

    for (int i = 0; i < 8; i++) begin
      set_lu(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].we, vecs[i].ld);
      chk(vecs[i].name, vecs[i].exp);
      clear_in();
      chk({vecs[i].name, "_gone"}, O_IDLE);
    end

    // Taken branch: 3 bubble cycles, busy on the last two.
    ex_branch_taken = 1'b1;
    chk("br_resolve", O_BR);
    ex_branch_taken = 1'b0;
    chk("br_flush1", O_FL);
    chk("br_flush2", O_FL);
    chk("br_done", O_IDLE);

    // Branch beats load-use; then freeze at cnt=2 and resume the remaining 2 bubbles.
    set_lu(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    ex_branch_taken = 1'b1;
    chk("prio_br_over_lu", O_BR);
    clear_in();
    mem_busy = 1'b1;
    chk("prio_freeze1", O_FRZ);
    chk("prio_freeze2", O_FRZ);
    mem_busy = 1'b0;
    set_lu(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    chk("prio_resume1_lu_masked", O_FL);
    clear_in();
    chk("prio_resume2", O_FL);
    chk("prio_done", O_IDLE);

    // Freeze 4 cycles with a branch in cycle 2: pending flush afterwards.
    mem_busy = 1'b1;
    chk("pend_frz1", O_FRZ0);
    ex_branch_taken = 1'b1;
    chk("pend_frz2", O_FRZ);
    ex_branch_taken = 1'b0;
    chk("pend_frz3", O_FRZ);
    chk("pend_frz4", O_FRZ);
    mem_busy = 1'b0;
    chk("pend_resolve", O_FL);
    chk("pend_flush1", O_FL);
    chk("pend_flush2", O_FL);
    chk("pend_done", O_IDLE);
    mem_busy = 1'b1;
    chk("pend_cleared_frz", O_FRZ0);
    mem_busy = 1'b0;
    chk("pend_cleared_exit", O_WEXIT);
    chk("pend_cleared_run", O_IDLE);

    // Load-use right after a freeze is still caught in the exit cycle.
    mem_busy = 1'b1;
    chk("lu_frz", O_FRZ0);
    mem_busy = 1'b0;
    set_lu(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    chk("lu_after_frz", 7'b1101001);
    clear_in();
    chk("lu_after_frz_run", O_IDLE);

`ifdef HAZARD_PERF_CNT_EN
    // Saturation: preset near the top, freeze 3 cycles.
    dut.u_perf_mem_wait.count = 32'hFFFF_FFFE;
    mem_busy = 1'b1;
    chk("sat_frz1", O_FRZ0);
    chk("sat_frz2", O_FRZ);
    chk("sat_frz3", O_FRZ);
    mem_busy = 1'b0;
    chk32("perf_mem_wait_sat", perf_mem_wait, 32'hFFFF_FFFF);
    chk("sat_exit", O_WEXIT);
    chk32("perf_mem_wait_stays", perf_mem_wait, 32'hFFFF_FFFF);
`endif

    // Reset pulse in the middle of a freeze.
    mem_busy = 1'b1;
    chk("rst_frz1", O_FRZ0);
    chk("rst_frz2", O_FRZ);
    rst_n = 1'b0;
    chk("rst_mid_wait", O_IDLE);
    rst_n = 1'b1;
    mem_busy = 1'b0;
    chk("rst_back_run", O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    chk32("rst_perf_lu", perf_load_use, 32'd0);
    chk32("rst_perf_flush", perf_flush, 32'd0);
    chk32("rst_perf_mem", perf_mem_wait, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
